// File: rtl/elevator_pkg.sv
// Shared types for the elevator controller.
//   state_e : controller state encoding
//   dir_e   : travel direction remembered between moves
package elevator_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StMoveUp    = 3'd1,
        StMoveDown  = 3'd2,
        StDoorOpen  = 3'd3,
        StDoorClose = 3'd4
    } state_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by travel and door dwell.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   load_i : restart the count; done_o then rises after TIME cycles
//   done_o : count has expired
module elevator_timer #(
    parameter int unsigned TIME = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic done_o
);

    localparam int unsigned CntW = (TIME > 1) ? $clog2(TIME) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(TIME - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded on the edge that enters a timed state, so done is seen in its TIME-th cycle.
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/elevator.sv
// Single-car elevator controller.
//   clk           : clock, rising edge
//   rst_n         : asynchronous reset, active-high
//   button_out    : hall calls, active-low, bit i = floor i
//   button_in     : car calls, active-low, bit i = floor i
//   open/close    : door commands (registered)
//   up/down       : motor commands (registered)
//   current_floor : one-hot car position
//   request       : pending requests per floor
module elevator
    import elevator_pkg::*;
#(
    parameter int unsigned TIME  = 3,
    parameter int unsigned n     = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] button_out,
    input  logic [n-1:0] button_in,
    output logic         open,
    output logic         close,
    output logic         up,
    output logic         down,
    output logic [n-1:0] current_floor,
    output logic [n-1:0] request
);

    localparam logic [WIDTH-1:0] TopFloor = WIDTH'(n - 1);

    state_e           state_q;
    dir_e             dir_q;
    logic [WIDTH-1:0] floor_q;
    logic [n-1:0]     request_q, request_d;
    logic             open_q, close_q, up_q, down_q;

    logic             timer_load, timer_done;
    logic [n-1:0]     req_set;
    logic             req_here, req_above, req_below;
    logic [WIDTH-1:0] floor_up, floor_dn;
    logic             arrive_up, arrive_dn;

    elevator_timer #(
        .TIME (TIME)
    ) u_timer (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .load_i (timer_load),
        .done_o (timer_done)
    );

    // Idle keeps the timer primed; expiry re-arms it for the next leg or the dwell.
    assign timer_load = (state_q == StIdle) || timer_done;

    always_comb begin
        req_set   = request_q | ~button_out | ~button_in;
        req_here  = request_q[floor_q];
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            if (request_q[i] && (i > int'(floor_q))) req_above = 1'b1;
            if (request_q[i] && (i < int'(floor_q))) req_below = 1'b1;
        end
        floor_up  = floor_q + 1'b1;
        floor_dn  = floor_q - 1'b1;
        arrive_up = (state_q == StMoveUp) && timer_done;
        arrive_dn = (state_q == StMoveDown) && timer_done;

        // The served floor is cleared on door-open entry and throughout the dwell,
        // so a press there while the door is open is absorbed.
        request_d = req_set;
        if ((state_q == StDoorOpen) || ((state_q == StIdle) && req_here)) begin
            request_d[floor_q] = 1'b0;
        end else if (arrive_up && req_set[floor_up]) begin
            request_d[floor_up] = 1'b0;
        end else if (arrive_dn && req_set[floor_dn]) begin
            request_d[floor_dn] = 1'b0;
        end

        current_floor          = '0;
        current_floor[floor_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= StIdle;
            dir_q     <= DirUp;
            floor_q   <= '0;
            request_q <= '0;
            open_q    <= 1'b0;
            close_q   <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            request_q <= request_d;
            case (state_q)
                StIdle: begin
                    if (req_here) begin
                        state_q <= StDoorOpen;
                        open_q  <= 1'b1;
                    end else if ((dir_q == DirUp && req_above) ||
                                 (dir_q == DirDown && !req_below && req_above)) begin
                        state_q <= StMoveUp;
                        dir_q   <= DirUp;
                        up_q    <= 1'b1;
                    end else if (req_below) begin
                        state_q <= StMoveDown;
                        dir_q   <= DirDown;
                        down_q  <= 1'b1;
                    end
                end
                StMoveUp: begin
                    if (timer_done) begin
                        floor_q <= floor_up;
                        if (floor_up == TopFloor) dir_q <= DirDown;
                        if (req_set[floor_up]) begin
                            state_q <= StDoorOpen;
                            up_q    <= 1'b0;
                            open_q  <= 1'b1;
                        end else if (floor_up == TopFloor) begin
                            state_q <= StIdle;
                            up_q    <= 1'b0;
                        end
                    end
                end
                StMoveDown: begin
                    if (timer_done) begin
                        floor_q <= floor_dn;
                        if (floor_dn == '0) dir_q <= DirUp;
                        if (req_set[floor_dn]) begin
                            state_q <= StDoorOpen;
                            down_q  <= 1'b0;
                            open_q  <= 1'b1;
                        end else if (floor_dn == '0) begin
                            state_q <= StIdle;
                            down_q  <= 1'b0;
                        end
                    end
                end
                StDoorOpen: begin
                    if (timer_done) begin
                        state_q <= StDoorClose;
                        open_q  <= 1'b0;
                        close_q <= 1'b1;
                    end
                end
                StDoorClose: begin
                    state_q <= StIdle;
                    close_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    open_q  <= 1'b0;
                    close_q <= 1'b0;
                    up_q    <= 1'b0;
                    down_q  <= 1'b0;
                end
            endcase
        end
    end

    assign open    = open_q;
    assign close   = close_q;
    assign up      = up_q;
    assign down    = down_q;
    assign request = request_q;

endmodule

// File: tb/tb_elevator.sv
// Directed bench for the elevator controller (TIME=3, n=4).
module tb_elevator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] button_out = 4'hF;
    logic [3:0] button_in = 4'hF;
    logic       open, close, up, down;
    logic [3:0] current_floor, request;

    int n_checks = 0;
    int n_pass   = 0;
    int excl_err = 0;
    int len;

    localparam int SelOpen  = 0;
    localparam int SelClose = 1;
    localparam int SelUp    = 2;
    localparam int SelDown  = 3;

    elevator #(
        .TIME  (3),
        .n     (4),
        .WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_out    (button_out),
        .button_in     (button_in),
        .open          (open),
        .close         (close),
        .up            (up),
        .down          (down),
        .current_floor (current_floor),
        .request       (request)
    );

    always #5 clk = ~clk;

    function automatic logic cmd(input int sel);
        case (sel)
            SelOpen:  return open;
            SelClose: return close;
            SelUp:    return up;
            default:  return down;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_for(input int sel, output bit ok);
        int t = 0;
        ok = 1'b0;
        while (!ok && t < 60) begin
            if (cmd(sel) === 1'b1) ok = 1'b1;
            else begin
                t++;
                @(negedge clk);
            end
        end
    endtask

    task automatic count_high(input int sel, output int cnt);
        cnt = 0;
        while (cmd(sel) === 1'b1 && cnt < 100) begin
            if ($countones({open, close, up, down}) > 1) excl_err++;
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic measure(input int sel, output int cnt);
        bit ok;
        wait_for(sel, ok);
        if (ok) count_high(sel, cnt);
        else cnt = -1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_floor", 32'(current_floor), 32'b0001);
        check("rst_request", 32'(request), 32'b0000);
        check("rst_cmds", 32'({open, close, up, down}), 32'b0000);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Two-floor call: floors 0 and 2 via hall buttons
        button_out = 4'b1010;
        @(negedge clk);
        button_out = 4'b1111;
        check("a_request_set", 32'(request), 32'b0101);
        measure(SelOpen, len);
        check("a_open0_len", 32'(len), 32'd3);
        measure(SelClose, len);
        check("a_close0_len", 32'(len), 32'd1);
        measure(SelUp, len);
        check("a_up_len", 32'(len), 32'd6);
        check("a_floor2", 32'(current_floor), 32'b0100);
        measure(SelOpen, len);
        check("a_open2_len", 32'(len), 32'd3);
        check("a_request_clr", 32'(request), 32'b0000);
        measure(SelClose, len);
        check("a_close2_len", 32'(len), 32'd1);
        repeat (2) @(negedge clk);

        // Downward call from floor 2, plus a same-floor press during the dwell
        button_in = 4'b1110;
        @(negedge clk);
        button_in = 4'b1111;
        measure(SelDown, len);
        check("b_down_len", 32'(len), 32'd6);
        check("b_floor0", 32'(current_floor), 32'b0001);
        check("b_open_started", 32'(open), 32'd1);
        button_out = 4'b1110;
        @(negedge clk);
        button_out = 4'b1111;
        count_high(SelOpen, len);
        check("b_open_len", 32'(len + 1), 32'd3);
        check("b_request_clr", 32'(request), 32'b0000);
        measure(SelClose, len);
        check("b_close_len", 32'(len), 32'd1);
        repeat (2) @(negedge clk);

        // Mid-motion pick-up at floor 1 on the way to floor 3
        button_in = 4'b0111;
        @(negedge clk);
        button_in = 4'b1111;
        measure(SelUp, len);
        check("c_up_started", 32'(len >= 1), 32'd1);
        // measure() above returned a full leg only if no stop was injected; redo properly
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        button_in = 4'b0111;
        @(negedge clk);
        button_in = 4'b1111;
        begin
            bit ok;
            wait_for(SelUp, ok);
            check("c_up_seen", 32'(ok), 32'd1);
        end
        button_out = 4'b1101;
        @(negedge clk);
        button_out = 4'b1111;
        count_high(SelUp, len);
        check("c_leg1_len", 32'(len + 1), 32'd3);
        check("c_floor1", 32'(current_floor), 32'b0010);
        check("c_req_pending3", 32'(request), 32'b1000);
        measure(SelOpen, len);
        check("c_open1_len", 32'(len), 32'd3);
        measure(SelClose, len);
        check("c_close1_len", 32'(len), 32'd1);
        measure(SelUp, len);
        check("c_leg2_len", 32'(len), 32'd6);
        check("c_floor3", 32'(current_floor), 32'b1000);
        measure(SelOpen, len);
        check("c_open3_len", 32'(len), 32'd3);
        measure(SelClose, len);
        check("c_close3_len", 32'(len), 32'd1);
        check("c_request_clr", 32'(request), 32'b0000);

        // No requests: stays idle with all commands low
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("d_idle_cmds", 32'({open, close, up, down}), 32'b0000);
        end
        check("d_floor3", 32'(current_floor), 32'b1000);

        // Reset during MOVE_UP
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        button_in = 4'b0111;
        @(negedge clk);
        button_in = 4'b1111;
        begin
            bit ok;
            wait_for(SelUp, ok);
            check("e_up_seen", 32'(ok), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("e_rst_cmds", 32'({open, close, up, down}), 32'b0000);
        check("e_rst_floor", 32'(current_floor), 32'b0001);
        check("e_rst_request", 32'(request), 32'b0000);
        button_in = 4'b0000;
        @(negedge clk);
        check("e_press_in_rst", 32'(request), 32'b0000);
        button_in = 4'b1111;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("e_post_rst_cmds", 32'({open, close, up, down}), 32'b0000);
        end

        check("exclusive_cmds", 32'(excl_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
